// File: rtl/mem_wb_pipe_reg_if.sv
// MEM->WB handshake bundle: upstream valid/ready plus payload, downstream head entry.
// master is the surrounding pipeline, slave is the pipeline register itself.
interface mem_wb_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              M_Valid;
  logic              M_Ready;
  logic [DATA_W-1:0] M_Dout;
  logic [DATA_W-1:0] M_ALUout;
  logic [REG_AW-1:0] M_Rw;
  logic              M_MemtoReg;
  logic              M_RegWr;
  logic              M_Overflow;

  logic              W_Ready;
  logic              W_Valid;
  logic [DATA_W-1:0] W_Dout;
  logic [DATA_W-1:0] W_ALUout;
  logic [REG_AW-1:0] W_Rw;
  logic              W_MemtoReg;
  logic              W_Overflow;
  logic              W_RegWr;
  logic [DATA_W-1:0] W_WrData;

  modport master (
    output M_Valid, M_Dout, M_ALUout, M_Rw, M_MemtoReg, M_RegWr, M_Overflow, W_Ready,
    input  M_Ready, W_Valid, W_Dout, W_ALUout, W_Rw, W_MemtoReg, W_Overflow, W_RegWr, W_WrData
  );

  modport slave (
    input  M_Valid, M_Dout, M_ALUout, M_Rw, M_MemtoReg, M_RegWr, M_Overflow, W_Ready,
    output M_Ready, W_Valid, W_Dout, W_ALUout, W_Rw, W_MemtoReg, W_Overflow, W_RegWr, W_WrData
  );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, one-entry skid buffer, flush,
// overflow write suppression, writeback-data select and a saturating stall counter.
module mem_wb_pipe_reg #(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter bit OVF_BLOCKS_WR = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  mem_wb_pipe_reg_if.slave bus,
  input  logic             Flush,
  output logic [CNT_W-1:0] Stall_Cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] aluout;
    logic [REG_AW-1:0] rw;
    logic              memtoreg;
    logic              regwr;
    logic              overflow;
  } entry_t;

  state_t           r_state;
  entry_t           r_head;
  entry_t           r_skid;
  logic             r_m_ready;
  logic [CNT_W-1:0] r_stall_cnt;

  entry_t w_m_entry;
  logic   w_valid;
  logic   w_acc;
  logic   w_pop;

  assign w_m_entry = '{dout:     bus.M_Dout,
                       aluout:   bus.M_ALUout,
                       rw:       bus.M_Rw,
                       memtoreg: bus.M_MemtoReg,
                       regwr:    bus.M_RegWr,
                       overflow: bus.M_Overflow};

  assign w_valid = (r_state != S_EMPTY);
  assign w_acc   = bus.M_Valid & r_m_ready;
  assign w_pop   = w_valid & bus.W_Ready;

  // The whole register is clocked on the falling edge to match the register-file timing.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values and ordering inside the block does not matter.
  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      // NOTE: head and skid are plain registers (not a RAM), so clearing them on reset is
      // cheap and guarantees W_* and W_WrData read zero while reset is held.
      r_state     <= S_EMPTY;
      r_head      <= '0;
      r_skid      <= '0;
      r_m_ready   <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      if (w_valid && !bus.W_Ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);

      if (Flush) begin
        r_state   <= S_EMPTY;
        r_m_ready <= 1'b1;
      end else begin
        unique case (r_state)
          S_EMPTY: begin
            if (w_acc) begin
              r_head  <= w_m_entry;
              r_state <= S_FULL;
            end
            r_m_ready <= 1'b1;
          end
          S_FULL: begin
            if (w_acc && w_pop) begin
              r_head    <= w_m_entry;
              r_m_ready <= 1'b1;
            end else if (w_acc) begin
              r_skid    <= w_m_entry;
              r_state   <= S_SKID;
              r_m_ready <= 1'b0;
            end else if (w_pop) begin
              r_state   <= S_EMPTY;
              r_m_ready <= 1'b1;
            end else begin
              r_m_ready <= 1'b1;
            end
          end
          S_SKID: begin
            // M_Ready is low here, so only a pop can move the state.
            if (w_pop) begin
              r_head    <= r_skid;
              r_state   <= S_FULL;
              r_m_ready <= 1'b1;
            end else begin
              r_m_ready <= 1'b0;
            end
          end
          default: begin
            r_state   <= S_EMPTY;
            r_m_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.M_Ready    = r_m_ready;
  assign bus.W_Valid    = w_valid;
  assign bus.W_Dout     = r_head.dout;
  assign bus.W_ALUout   = r_head.aluout;
  assign bus.W_Rw       = r_head.rw;
  assign bus.W_MemtoReg = r_head.memtoreg;
  assign bus.W_Overflow = r_head.overflow & w_valid;
  assign bus.W_RegWr    = r_head.regwr & w_valid & ~(OVF_BLOCKS_WR & r_head.overflow);
  assign bus.W_WrData   = r_head.memtoreg ? r_head.dout : r_head.aluout;
  assign Stall_Cnt      = r_stall_cnt;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: two instances share stimulus, one with overflow write
// blocking and a 16-bit counter, one with reporting-only overflow and a 4-bit counter.
module tb_mem_wb_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              CLK;
  logic              RSTn;
  logic              m_valid;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_aluout;
  logic [REG_AW-1:0] m_rw;
  logic              m_memtoreg;
  logic              m_regwr;
  logic              m_overflow;
  logic              w_ready;
  logic              flush;
  logic [15:0]       stall_cnt_a;
  logic [3:0]        stall_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_pipe_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) if_a ();
  mem_wb_pipe_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) if_b ();

  assign if_a.M_Valid    = m_valid;
  assign if_a.M_Dout     = m_dout;
  assign if_a.M_ALUout   = m_aluout;
  assign if_a.M_Rw       = m_rw;
  assign if_a.M_MemtoReg = m_memtoreg;
  assign if_a.M_RegWr    = m_regwr;
  assign if_a.M_Overflow = m_overflow;
  assign if_a.W_Ready    = w_ready;

  assign if_b.M_Valid    = m_valid;
  assign if_b.M_Dout     = m_dout;
  assign if_b.M_ALUout   = m_aluout;
  assign if_b.M_Rw       = m_rw;
  assign if_b.M_MemtoReg = m_memtoreg;
  assign if_b.M_RegWr    = m_regwr;
  assign if_b.M_Overflow = m_overflow;
  assign if_b.W_Ready    = w_ready;

  mem_wb_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OVF_BLOCKS_WR(1'b1), .CNT_W(16)) dut_a (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .bus       (if_a.slave),
    .Flush     (flush),
    .Stall_Cnt (stall_cnt_a)
  );

  mem_wb_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OVF_BLOCKS_WR(1'b0), .CNT_W(4)) dut_b (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .bus       (if_b.slave),
    .Flush     (flush),
    .Stall_Cnt (stall_cnt_b)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [31:0] alu, input logic [31:0] dout,
                       input logic mtr, input logic [4:0] rw, input logic regwr,
                       input logic ovf);
    m_valid    = valid;
    m_aluout   = alu;
    m_dout     = dout;
    m_memtoreg = mtr;
    m_rw       = rw;
    m_regwr    = regwr;
    m_overflow = ovf;
  endtask

  // Advance one falling edge and settle just after it.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    RSTn    = 1'b1;
    w_ready = 1'b0;
    flush   = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Asynchronous reset, no clock edge in between.
    #2 RSTn = 1'b0;
    #1;
    check("rst_w_valid",  if_a.W_Valid,  0);
    check("rst_w_regwr",  if_a.W_RegWr,  0);
    check("rst_w_wrdata", if_a.W_WrData, 0);
    check("rst_m_ready",  if_a.M_Ready,  1);
    check("rst_stall",    stall_cnt_a,   0);
    @(negedge CLK);
    #1 RSTn = 1'b1;

    // Passthrough with ALUout writeback.
    w_ready = 1'b1;
    drive(1'b1, 32'h11, 32'h99, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    check("pt_w_valid",  if_a.W_Valid,  1);
    check("pt_w_wrdata", if_a.W_WrData, 32'h11);
    check("pt_w_regwr",  if_a.W_RegWr,  1);
    check("pt_w_rw",     if_a.W_Rw,     5);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check("pt_drain_valid", if_a.W_Valid, 0);
    check("pt_drain_regwr", if_a.W_RegWr, 0);

    // Memory-data writeback select.
    drive(1'b1, 32'h22, 32'h77, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    check("mtr_w_wrdata", if_a.W_WrData, 32'h77);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();

    // Back-to-back accept while popping keeps FULL with new head.
    drive(1'b1, 32'h31, 32'h0, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h32, 32'h0, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    check("b2b_w_aluout", if_a.W_ALUout, 32'h32);
    check("b2b_m_ready",  if_a.M_Ready,  1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check("b2b_drain_valid", if_a.W_Valid, 0);

    // Skid: two pushes with WB stalled.
    w_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    check("skid_a_head",  if_a.W_ALUout, 32'hA);
    check("skid_a_ready", if_a.M_Ready,  1);
    drive(1'b1, 32'hB, 32'h0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    check("skid_m_ready", if_a.M_Ready,  0);
    check("skid_head",    if_a.W_ALUout, 32'hA);
    check("skid_stall1",  stall_cnt_a,   1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check("skid_hold_head", if_a.W_ALUout, 32'hA);
    check("skid_stall2",    stall_cnt_a,   2);
    w_ready = 1'b1;
    tick();
    check("skid_pop_head",  if_a.W_ALUout, 32'hB);
    check("skid_pop_valid", if_a.W_Valid,  1);
    check("skid_pop_ready", if_a.M_Ready,  1);
    tick();
    check("skid_empty",        if_a.W_Valid, 0);
    check("skid_stall_held",   stall_cnt_a,  2);
    check("skid_stall_held_b", stall_cnt_b,  2);

    // Overflow suppresses the write only when blocking is enabled.
    w_ready = 1'b0;
    drive(1'b1, 32'h44, 32'h0, 1'b0, 5'd6, 1'b1, 1'b1);
    tick();
    check("ovf_a_regwr", if_a.W_RegWr,    0);
    check("ovf_a_flag",  if_a.W_Overflow, 1);
    check("ovf_b_regwr", if_b.W_RegWr,    1);
    check("ovf_b_flag",  if_b.W_Overflow, 1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    w_ready = 1'b1;
    tick();
    check("ovf_gone_flag", if_a.W_Overflow, 0);
    check("ovf_gone_regwr_b", if_b.W_RegWr, 0);

    // Flush from SKID with a valid upstream request.
    w_ready = 1'b0;
    drive(1'b1, 32'hA1, 32'h0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hB1, 32'h0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    check("fl_pre_ready", if_a.M_Ready, 0);
    check("fl_pre_stall", stall_cnt_a,  3);
    flush = 1'b1;
    drive(1'b1, 32'hC, 32'h0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    check("fl_w_valid", if_a.W_Valid, 0);
    check("fl_m_ready", if_a.M_Ready, 1);
    check("fl_w_regwr", if_a.W_RegWr, 0);
    check("fl_stall",   stall_cnt_a,  4);
    // Flush while EMPTY with an accepted request: the entry is discarded.
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    w_ready = 1'b1;
    tick();
    check("fl_discard_valid", if_a.W_Valid, 0);
    check("fl_discard_stall", stall_cnt_a,  4);

    // Saturation of the 4-bit counter; 16-bit counter keeps counting.
    w_ready = 1'b0;
    drive(1'b1, 32'h55, 32'h0, 1'b0, 5'd11, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_b_20", stall_cnt_b, 15);
    check("sat_a_20", stall_cnt_a, 24);
    tick();
    tick();
    check("sat_b_22", stall_cnt_b, 15);
    check("sat_a_22", stall_cnt_a, 26);

    // Reset mid-operation drops the held entry immediately.
    #2 RSTn = 1'b0;
    #1;
    check("mrst_w_valid",  if_a.W_Valid,  0);
    check("mrst_w_aluout", if_a.W_ALUout, 0);
    check("mrst_m_ready",  if_a.M_Ready,  1);
    check("mrst_stall",    stall_cnt_a,   0);
    #1 RSTn = 1'b1;
    w_ready = 1'b1;
    drive(1'b1, 32'h66, 32'h0, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    check("mrst_first_valid", if_a.W_Valid,  1);
    check("mrst_first_data",  if_a.W_ALUout, 32'h66);
    check("mrst_first_stall", stall_cnt_b,   0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
